pwm_shadow: RTL and testbench
=============================

PWM_SHADOW -- requirements
Module: pwm_shadow

Interface
REQ-001 SHALL have parameter W, default 8, the width of the counter and of all config fields.
REQ-002 SHALL have parameter PERIOD_RST, default 255, the active period value after reset.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: run enable; when low, the counter is held.
REQ-006 SHALL have port cfg_valid, input, 1 bit: config offer from the upstream controller (for example, button-driven duty stepping).
REQ-007 SHALL have port cfg_period, input, W bits: requested period value P; the cycle length is P+1.
REQ-008 SHALL have port cfg_duty, input, W bits: requested high time D, in clocks.
REQ-009 SHALL have port cfg_offset, input, W bits: requested rising-edge position O within the cycle.
REQ-010 SHALL have port cfg_ready, output, 1 bit: high when the pending slot is empty.
REQ-011 SHALL have port out, output, 1 bit: registered PWM output, feeding LED or signal pins and AND-gating logic downstream.
REQ-012 SHALL have port period_end, output, 1 bit: one-clock strobe on the last count of a cycle.
REQ-013 SHALL have port cnt, output, W bits: the current count, registered.

Function
REQ-014 SHALL hold three register sets: active (P_a, D_a, O_a), pending (P_p, D_p, O_p) and a pend_full flag; cfg_ready SHALL equal !pend_full.
REQ-015 SHALL, when cfg_valid && cfg_ready, capture the cfg_* fields into pending and set pend_full on the same edge; cfg_valid while pend_full SHALL be ignored, with no overwrite.
REQ-016 SHALL, when en=1, count cnt 0,1,...,P_a and then wrap to 0; period_end SHALL be 1 exactly while cnt==P_a and en=1.
REQ-017 SHALL, when en=1, pend_full=1 and cnt==P_a, copy pending to active and clear pend_full on that edge; the new values govern from the cycle whose cnt=0; cfg_ready SHALL be high in that cnt=0 cycle.
REQ-018 SHALL, when en=0, force cnt to 0, out to 0 and period_end to 0; a pending config SHALL be copied to active on the next edge and pend_full cleared.
REQ-019 SHALL, when a capture and a transfer coincide, perform the transfer first; the incoming offer cannot be accepted that edge because cfg_ready was low.
REQ-020 SHALL drive out=1 in the same cycle as cnt=k iff en=1, k>=O_a and k<O_a+D_a, with the sum computed at W+1 bits (no wrap).
REQ-021 SHALL register out from next-state values so that it is aligned with cnt, with no extra cycle of lag.
REQ-022 SHALL keep out at 0 for the whole cycle when D_a=0.
REQ-023 SHALL, when O_a+D_a>P_a+1, keep out at 1 from O_a through P_a with no wrap into the next cycle.
REQ-024 SHALL keep out at 0 for the whole cycle when O_a>P_a.
REQ-025 SHALL, when P_a=0, have cnt stay at 0, period_end=1 every enabled cycle, and out=1 iff D_a>=1 and O_a=0.
REQ-026 SHALL not add any combinational path from cfg_* inputs to out, cnt or period_end.

Reset
REQ-027 SHALL, on rst high, asynchronously set cnt=0, out=0, period_end=0, pend_full=0 (so cfg_ready=1), P_a=PERIOD_RST, D_a=0, O_a=0 and pending=0.
REQ-028 SHALL, on rst asserted mid-cycle or mid-handshake, discard the pending config and leave no partial transfer.
REQ-029 SHALL start counting from cnt=0 on the first clock edge after rst is released when en=1.

Verification
REQ-030 SHALL cover: W=8, en=1, cfg P=9 D=3 O=0 offered at idle -> accepted, applied after the current 256-clock cycle; then out high at cnt 0..2, low at cnt 3..9; period_end every 10 clocks.
REQ-031 SHALL cover: with P=9 active, cfg P=9 D=5 O=5 -> out high at cnt 5..9 only; D=7 O=5 -> clamped to 5..9, low at cnt 0.
REQ-032 SHALL cover: two offers 1 clock apart while the first is pending -> second ignored, cfg_ready low until the wrap, then high at cnt=0.
REQ-033 SHALL cover: D=0 -> out constantly 0; O=12 with P=9 -> out constantly 0; P=0 D=1 O=0 -> out constantly 1, period_end constantly 1.
REQ-034 SHALL cover: en dropped at cnt=4 -> next cycle cnt=0, out=0, period_end=0; a pending config applied while en=0; after en rises, counting restarts at 0 with the new config.
REQ-035 SHALL cover: rst pulsed at cnt=6 with a config pending -> immediately cnt=0, out=0, cfg_ready=1, P_a=255, D_a=0.

Source files
------------

// File: rtl/pwm_shadow.sv
// pwm_shadow: PWM generator with a one-deep shadowed config slot.
// Configs are staged in a pending slot and swapped in at cycle boundaries.
//
// Parameters:
//   W          - counter and config field width
//   PERIOD_RST - active period value after reset
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - run enable; low holds the counter at 0
//   cfg_valid  - config offer from the upstream controller
//   cfg_period - requested period P (cycle length P+1)
//   cfg_duty   - requested high time D in clocks
//   cfg_offset - requested rising-edge position O
//   cfg_ready  - pending slot empty
//   out        - registered PWM output, aligned with cnt
//   period_end - strobe on the last count of a cycle
//   cnt        - current count, registered
module pwm_shadow #(
    parameter int unsigned W          = 8,
    parameter int unsigned PERIOD_RST = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_duty,
    input  logic [W-1:0] cfg_offset,
    output logic         cfg_ready,
    output logic         out,
    output logic         period_end,
    output logic [W-1:0] cnt
);

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] duty;
        logic [W-1:0] offset;
    } cfg_t;

    localparam cfg_t ACT_RST = '{
        period: W'(PERIOD_RST),
        duty:   '0,
        offset: '0
    };

    cfg_t act_q;
    cfg_t pend_q;
    logic pend_full;
    logic running;

    cfg_t         act_nxt;
    logic [W-1:0] cnt_nxt;
    logic         out_nxt;
    logic         pe_nxt;
    logic         start;
    logic         wrap;
    logic         xfer;
    logic         accept;

    // High-window test; the end bound is W+1 bits so O+D never wraps.
    function automatic logic in_window(
        input logic [W-1:0] k,
        input cfg_t         c
    );
        logic [W:0] lim;
        lim = {1'b0, c.offset} + {1'b0, c.duty};
        return (k >= c.offset) && ({1'b0, k} < lim);
    endfunction

    assign cfg_ready = !pend_full;
    assign accept    = cfg_valid && !pend_full;

    // The first enabled edge after idle loads cnt=0 so that the
    // cnt=0 cycle of a fresh run has a correct out/period_end.
    assign start = en && !running;
    assign wrap  = running && (cnt == act_q.period);

    // Any cycle boundary (wrap, run start, or idle) swaps the
    // pending config in.
    assign xfer = pend_full && (!en || start || wrap);

    always_comb begin
        act_nxt = xfer ? pend_q : act_q;
        cnt_nxt = '0;
        if (en && !start && !wrap) begin
            cnt_nxt = cnt + W'(1);
        end
        // out and period_end come from next-state values so they
        // line up with the registered cnt.
        out_nxt = en && in_window(cnt_nxt, act_nxt);
        pe_nxt  = en && (cnt_nxt == act_nxt.period);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            out        <= 1'b0;
            period_end <= 1'b0;
            running    <= 1'b0;
            pend_full  <= 1'b0;
            pend_q     <= '0;
            act_q      <= ACT_RST;
        end else begin
            cnt        <= cnt_nxt;
            out        <= out_nxt;
            period_end <= pe_nxt;
            running    <= en;
            act_q      <= act_nxt;
            // Transfer and capture never coincide: a transfer needs
            // pend_full, which blocks acceptance.
            if (xfer) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_q    <= '{
                    period: cfg_period,
                    duty:   cfg_duty,
                    offset: cfg_offset
                };
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_shadow.sv
// tb_pwm_shadow: directed self-checking bench for pwm_shadow.
// Scenario tasks with hand-derived expectations.
module tb_pwm_shadow;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_duty;
    logic [W-1:0] cfg_offset;
    logic         cfg_ready;
    logic         out;
    logic         period_end;
    logic [W-1:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_shadow #(
        .W(W),
        .PERIOD_RST(255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_offset (cfg_offset),
        .cfg_ready  (cfg_ready),
        .out        (out),
        .period_end (period_end),
        .cnt        (cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one full cycle from cnt=0 and checks every count.
    task automatic run_cycle(input string name, input int p,
                             input int d, input int o);
        logic eo;
        logic ep;
        for (int k = 0; k <= p; k++) begin
            eo = (k >= o) && (k < o + d);
            ep = (k == p);
            checks++;
            if (cnt !== W'(k)) begin
                errors++;
                $display("FAIL %s cnt: got %0d expected %0d",
                         name, cnt, k);
            end
            checks++;
            if (out !== eo) begin
                errors++;
                $display("FAIL %s out@%0d: got %b expected %b",
                         name, k, out, eo);
            end
            checks++;
            if (period_end !== ep) begin
                errors++;
                $display("FAIL %s period_end@%0d: got %b expected %b",
                         name, k, period_end, ep);
            end
            tick();
        end
    endtask

    // Offers a config, then waits for the swap at the next boundary.
    task automatic apply_cfg(input string name, input int p,
                             input int d, input int o);
        int n;
        cfg_period = W'(p);
        cfg_duty   = W'(d);
        cfg_offset = W'(o);
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: cfg_ready got %b expected 0",
                     name, cfg_ready);
        end
        n = 0;
        while (cfg_ready !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s transfer timeout: cfg_ready got %b expected 1",
                     name, cfg_ready);
        end
        checks++;
        if (cnt !== '0) begin
            errors++;
            $display("FAIL %s swap cnt: got %0d expected 0", name, cnt);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_offset = '0;
        tick();
        tick();
        checks++;
        if (cnt !== '0) begin
            errors++;
            $display("FAIL reset cnt: got %0d expected 0", cnt);
        end
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL reset out: got %b expected 0", out);
        end
        checks++;
        if (period_end !== 1'b0) begin
            errors++;
            $display("FAIL reset period_end: got %b expected 0", period_end);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset cfg_ready: got %b expected 1", cfg_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        en         = 1'b1;
        cfg_period = 8'd9;
        cfg_duty   = 8'd3;
        cfg_offset = 8'd0;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic accept: cfg_ready got %b expected 0",
                     cfg_ready);
        end
        run_cycle("default", 255, 0, 0);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic swap: cfg_ready got %b expected 1",
                     cfg_ready);
        end
        run_cycle("p9d3o0_a", 9, 3, 0);
        run_cycle("p9d3o0_b", 9, 3, 0);
    endtask

    task automatic test_offset();
        apply_cfg("d5o5", 9, 5, 5);
        run_cycle("d5o5", 9, 5, 5);
        apply_cfg("d7o5", 9, 7, 5);
        run_cycle("d7o5_clamp", 9, 7, 5);
    endtask

    task automatic test_back_to_back();
        cfg_period = 8'd9;
        cfg_duty   = 8'd2;
        cfg_offset = 8'd1;
        cfg_valid  = 1'b1;
        tick();
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b first: cfg_ready got %b expected 0",
                     cfg_ready);
        end
        cfg_duty   = 8'd6;
        cfg_offset = 8'd0;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b second: cfg_ready got %b expected 0",
                     cfg_ready);
        end
        for (int k = 3; k <= 9; k++) begin
            tick();
            checks++;
            if (cfg_ready !== 1'b0 || cnt !== W'(k)) begin
                errors++;
                $display("FAIL b2b hold@%0d: ready %b cnt %0d expected 0 %0d",
                         k, cfg_ready, cnt, k);
            end
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b1 || cnt !== '0) begin
            errors++;
            $display("FAIL b2b wrap: ready %b cnt %0d expected 1 0",
                     cfg_ready, cnt);
        end
        run_cycle("b2b_first_kept", 9, 2, 1);
    endtask

    task automatic test_degenerate();
        apply_cfg("d0", 9, 0, 0);
        run_cycle("d0", 9, 0, 0);
        apply_cfg("o12", 9, 4, 12);
        run_cycle("o12", 9, 4, 12);
        apply_cfg("p0", 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            run_cycle("p0", 0, 1, 0);
        end
        apply_cfg("restore", 9, 3, 0);
        run_cycle("restore", 9, 3, 0);
    endtask

    task automatic test_enable();
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checks++;
        if (cnt !== 8'd4) begin
            errors++;
            $display("FAIL en pre-drop cnt: got %0d expected 4", cnt);
        end
        en         = 1'b0;
        cfg_period = 8'd9;
        cfg_duty   = 8'd2;
        cfg_offset = 8'd2;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cnt !== '0 || out !== 1'b0 || period_end !== 1'b0) begin
            errors++;
            $display("FAIL en drop: cnt %0d out %b pe %b expected 0 0 0",
                     cnt, out, period_end);
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL en capture: cfg_ready got %b expected 0",
                     cfg_ready);
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL en idle swap: cfg_ready got %b expected 1",
                     cfg_ready);
        end
        tick();
        checks++;
        if (cnt !== '0 || out !== 1'b0 || period_end !== 1'b0) begin
            errors++;
            $display("FAIL en hold: cnt %0d out %b pe %b expected 0 0 0",
                     cnt, out, period_end);
        end
        en = 1'b1;
        tick();
        run_cycle("en_restart", 9, 2, 2);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        cfg_period = 8'd9;
        cfg_duty   = 8'd5;
        cfg_offset = 8'd0;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (cnt !== 8'd6 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid pre: cnt %0d ready %b expected 6 0",
                     cnt, cfg_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cnt !== '0 || out !== 1'b0 || period_end !== 1'b0) begin
            errors++;
            $display("FAIL rstmid async: cnt %0d out %b pe %b expected 0 0 0",
                     cnt, out, period_end);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid cfg_ready: got %b expected 1", cfg_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        run_cycle("post_rst", 255, 0, 0);
        checks++;
        if (cnt !== '0 || out !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid discard: cnt %0d out %b ready %b expected 0 0 1",
                     cnt, out, cfg_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset();
        test_back_to_back();
        test_degenerate();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
